// File: rtl/pingpong_block_ram.sv
// Two-bank ping-pong block buffer: the writer fills one N*N bank while the reader drains the other.
// Define PINGPONG_BLOCK_RAM_TRANSPOSE_EN to read each block column-major (on-the-fly transpose).
module pingpong_block_ram #(
    parameter int DW = 8,
    parameter int N  = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_last,
    output logic [1:0]    full_cnt
);

    localparam int L  = $clog2(N);
    localparam int AW = 2 * L;
    localparam int D  = N * N;

    typedef enum logic [1:0] {EMPTY, FULL, DRAINING} bank_t;

    bank_t           st     [2];
    bank_t           st_nxt [2];
    logic            wp, rp;
    logic [AW-1:0]   wa, ra, raddr;
    logic            issued_all;
    logic [DW-1:0]   mem0 [D];
    logic [DW-1:0]   mem1 [D];

    logic wr_fire, wr_done, rd_fire, drain_done, out_free, start, issue;

    assign wr_ready   = (st[wp] == EMPTY);
    assign wr_fire    = wr_valid && wr_ready;
    assign wr_done    = wr_fire && (wa == '1);
    assign rd_fire    = rd_valid && rd_ready;
    assign drain_done = rd_fire && rd_last;
    assign out_free   = !rd_valid || rd_ready;
    assign start      = (st[rp] == FULL) && out_free;
    // The output register doubles as the RAM read register, so a read is only
    // issued when the word currently held is gone (or leaving this cycle).
    assign issue      = start || ((st[rp] == DRAINING) && !issued_all && out_free);

`ifdef PINGPONG_BLOCK_RAM_TRANSPOSE_EN
    assign raddr = {ra[L-1:0], ra[AW-1:L]};
`else
    assign raddr = ra;
`endif

    always_comb begin
        st_nxt[0] = st[0];
        st_nxt[1] = st[1];
        if (wr_done)    st_nxt[wp] = FULL;
        if (start)      st_nxt[rp] = DRAINING;
        if (drain_done) st_nxt[rp] = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st[0]      <= EMPTY;
            st[1]      <= EMPTY;
            wp         <= 1'b0;
            rp         <= 1'b0;
            wa         <= '0;
            ra         <= '0;
            issued_all <= 1'b0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            full_cnt   <= '0;
        end else begin
            st[0] <= st_nxt[0];
            st[1] <= st_nxt[1];
            if (wr_fire) begin
                wa <= wa + AW'(1);
                if (wr_done) wp <= ~wp;
            end
            if (issue) begin
                rd_valid <= 1'b1;
                rd_last  <= (ra == '1);
                ra       <= ra + AW'(1);
                if (ra == '1) issued_all <= 1'b1;
            end else if (rd_fire) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
            if (drain_done) begin
                rp         <= ~rp;
                issued_all <= 1'b0;
            end
            full_cnt <= {1'b0, st[0] != EMPTY} + {1'b0, st[1] != EMPTY};
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            if (wp) mem1[wa] <= wr_data;
            else    mem0[wa] <= wr_data;
        end
        if (issue) rd_data <= rp ? mem1[raddr] : mem0[raddr];
    end

endmodule

// File: tb/tb_pingpong_block_ram.sv
// Directed self-checking bench for pingpong_block_ram (DW=8, N=8); honours PINGPONG_BLOCK_RAM_TRANSPOSE_EN.
module tb_pingpong_block_ram;

    localparam int DW = 8;
    localparam int N  = 8;
    localparam int D  = N * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic [1:0]    full_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pingpong_block_ram #(.DW(DW), .N(N)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .full_cnt(full_cnt)
    );

    // Address fetched for read index k (k = c*N + r -> r*N + c when transposing).
    function automatic int addr_of(input int k);
`ifdef PINGPONG_BLOCK_RAM_TRANSPOSE_EN
        return (k % N) * N + k / N;
`else
        return k;
`endif
    endfunction

    function automatic logic [DW-1:0] expd(input int base, input int k);
        return DW'(base + addr_of(k));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes one block whose word at address a is base+a.
    task automatic write_block(input int base);
        int a = 0;
        int guard = 0;
        logic acc;
        wr_valid = 1'b1;
        while (a < D && guard < 1000) begin
            wr_data = DW'(base + a);
            acc = wr_ready;
            tick();
            if (acc) a++;
            guard++;
        end
        wr_valid = 1'b0;
        if (a < D) begin
            checks++; errors++;
            $display("FAIL write_block_timeout got %0d words need %0d", a, D);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
        tick();
        rst = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b need 0", rd_valid); end
        checks++; if (rd_last !== 1'b0) begin errors++; $display("FAIL reset_rd_last got %b need 0", rd_last); end
        checks++; if (full_cnt !== 2'd0) begin errors++; $display("FAIL reset_full_cnt got %0d need 0", full_cnt); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b need 1", wr_ready); end
    endtask

    task automatic test_single_block();
        int k = 0;
        int gaps = 0;
        rd_ready = 1'b1;
        write_block(0);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_latency_t1 rd_valid got %b need 0", rd_valid); end
        tick();
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL single_latency_t2 rd_valid got %b need 1", rd_valid); end
        for (int cyc = 0; cyc < 200 && k < D; cyc++) begin
            if (rd_valid) begin
                checks++; if (rd_data !== expd(0, k)) begin errors++; $display("FAIL single_data k=%0d got %0d need %0d", k, rd_data, expd(0, k)); end
                checks++; if (rd_last !== (k == D - 1)) begin errors++; $display("FAIL single_last k=%0d got %b need %b", k, rd_last, k == D - 1); end
                k++;
            end else begin
                gaps++;
            end
            tick();
        end
        checks++; if (k != D) begin errors++; $display("FAIL single_count got %0d need %0d", k, D); end
        checks++; if (gaps != 0) begin errors++; $display("FAIL single_gaps got %0d need 0", gaps); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_idle_after rd_valid got %b need 0", rd_valid); end
    endtask

    task automatic test_backpressure();
        int k = 0;
        int stall = 0;
        rd_ready = 1'b1;
        write_block(100);
        for (int cyc = 0; cyc < 300 && k < D; cyc++) begin
            if (k == 10 && (stall > 0 || rd_valid) && stall < 5) begin
                rd_ready = 1'b0;
                checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid stall=%0d got %b need 1", stall, rd_valid); end
                checks++; if (rd_data !== expd(100, 10)) begin errors++; $display("FAIL bp_hold_data stall=%0d got %0d need %0d", stall, rd_data, expd(100, 10)); end
                stall++;
            end else begin
                rd_ready = 1'b1;
                if (rd_valid) begin
                    checks++; if (rd_data !== expd(100, k)) begin errors++; $display("FAIL bp_data k=%0d got %0d need %0d", k, rd_data, expd(100, k)); end
                    checks++; if (rd_last !== (k == D - 1)) begin errors++; $display("FAIL bp_last k=%0d got %b need %b", k, rd_last, k == D - 1); end
                    k++;
                end
            end
            tick();
        end
        rd_ready = 1'b1;
        checks++; if (k != D) begin errors++; $display("FAIL bp_count got %0d need %0d", k, D); end
    endtask

    task automatic test_both_full();
        int k = 0;
        logic first_last;
        rd_ready = 1'b0;
        write_block(0);
        write_block(64);
        tick();
        checks++; if (full_cnt !== 2'd2) begin errors++; $display("FAIL full_cnt_two got %0d need 2", full_cnt); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready got %b need 0", wr_ready); end
        wr_valid = 1'b1; wr_data = 8'hEE;
        tick();
        wr_valid = 1'b0;
        checks++; if (full_cnt !== 2'd2) begin errors++; $display("FAIL full_after_drop got %0d need 2", full_cnt); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_drop_wr_ready got %b need 0", wr_ready); end
        rd_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && k < 2 * D; cyc++) begin
            first_last = 1'b0;
            if (rd_valid) begin
                checks++; if (rd_data !== expd((k / D) * D, k % D)) begin errors++; $display("FAIL full_data k=%0d got %0d need %0d", k, rd_data, expd((k / D) * D, k % D)); end
                checks++; if (rd_last !== (k % D == D - 1)) begin errors++; $display("FAIL full_last k=%0d got %b need %b", k, rd_last, k % D == D - 1); end
                if (k == D - 1) begin
                    first_last = 1'b1;
                    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready_before_last got %b need 0", wr_ready); end
                end
                k++;
            end
            tick();
            if (first_last) begin
                checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_last got %b need 1", wr_ready); end
            end
        end
        checks++; if (k != 2 * D) begin errors++; $display("FAIL full_count got %0d need %0d", k, 2 * D); end
    endtask

    task automatic test_streaming();
        int wi = 0;
        int ri = 0;
        int gap = 0;
        int maxgap = 0;
        int maxfc = 0;
        logic wacc;
        rd_ready = 1'b1;
        for (int cyc = 0; cyc < 2000 && ri < 4 * D; cyc++) begin
            wr_valid = (wi < 4 * D);
            wr_data  = DW'(wi);
            wacc = wr_valid && wr_ready;
            if (int'(full_cnt) > maxfc) maxfc = int'(full_cnt);
            if (rd_valid) begin
                checks++; if (rd_data !== expd((ri / D) * D, ri % D)) begin errors++; $display("FAIL stream_data i=%0d got %0d need %0d", ri, rd_data, expd((ri / D) * D, ri % D)); end
                checks++; if (rd_last !== (ri % D == D - 1)) begin errors++; $display("FAIL stream_last i=%0d got %b need %b", ri, rd_last, ri % D == D - 1); end
                if (gap > maxgap) maxgap = gap;
                gap = 0;
                ri++;
            end else if (ri > 0) begin
                gap++;
            end
            tick();
            if (wacc) wi++;
        end
        wr_valid = 1'b0;
        checks++; if (ri != 4 * D) begin errors++; $display("FAIL stream_count got %0d need %0d", ri, 4 * D); end
        checks++; if (maxgap > 1) begin errors++; $display("FAIL stream_gap got %0d need <=1", maxgap); end
        checks++; if (maxfc > 2) begin errors++; $display("FAIL stream_full_cnt got %0d need <=2", maxfc); end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            wr_data = DW'(i);
            tick();
        end
        wr_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rstw_rd_valid got %b need 0", rd_valid); end
        checks++; if (full_cnt !== 2'd0) begin errors++; $display("FAIL rstw_full_cnt got %0d need 0", full_cnt); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rstw_wr_ready got %b need 1", wr_ready); end
        rd_ready = 1'b1;
        write_block(50);
        for (int cyc = 0; cyc < 200 && !(rd_valid && k == 20); cyc++) begin
            if (rd_valid) begin
                checks++; if (rd_data !== expd(50, k)) begin errors++; $display("FAIL rstr_data k=%0d got %0d need %0d", k, rd_data, expd(50, k)); end
                k++;
            end
            tick();
        end
        checks++; if (k != 20) begin errors++; $display("FAIL rstr_reach got %0d need 20", k); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rstr_rd_valid got %b need 0", rd_valid); end
        checks++; if (full_cnt !== 2'd0) begin errors++; $display("FAIL rstr_full_cnt got %0d need 0", full_cnt); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rstr_wr_ready got %b need 1", wr_ready); end
        k = 0;
        write_block(200);
        for (int cyc = 0; cyc < 200 && k < D; cyc++) begin
            if (rd_valid) begin
                checks++; if (rd_data !== expd(200, k)) begin errors++; $display("FAIL fresh_data k=%0d got %0d need %0d", k, rd_data, expd(200, k)); end
                checks++; if (rd_last !== (k == D - 1)) begin errors++; $display("FAIL fresh_last k=%0d got %b need %b", k, rd_last, k == D - 1); end
                k++;
            end
            tick();
        end
        checks++; if (k != D) begin errors++; $display("FAIL fresh_count got %0d need %0d", k, D); end
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; wr_data = '0;
        tick();
        test_reset();
        test_single_block();
        test_backpressure();
        test_both_full();
        test_streaming();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
